// File: rtl/dmem_pkg.sv
// Shared funct3 decoding for the data-memory load/store unit.
package dmem_pkg;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LD  = 3'b011,
    LBU = 3'b100,
    LHU = 3'b101,
    LWU = 3'b110
  } funct3_e;

  // Store encodings reuse the load codes of the same width.
  localparam funct3_e SB = LB;
  localparam funct3_e SH = LH;
  localparam funct3_e SW = LW;
  localparam funct3_e SD = LD;

  typedef enum logic {
    EMPTY,
    FULL
  } state_e;

  function automatic int unsigned size_bytes(input logic [2:0] funct3);
    return 32'd1 << funct3[1:0];
  endfunction

  function automatic logic is_unsigned(input logic [2:0] funct3);
    return funct3[2];
  endfunction

  function automatic logic legal(input logic [2:0] funct3, input logic we,
                                 input int unsigned data_w);
    logic wide;
    wide = (data_w == 32'd64);
    if (we) return !funct3[2] && ((funct3[1:0] != 2'b11) || wide);
    case (funct3_e'(funct3))
      LB, LH, LW, LBU, LHU: return 1'b1;
      LD, LWU:              return wide;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store enables/data, load extract+extend, error flag.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter  int unsigned DATA_W = 32,
  localparam int unsigned NB     = DATA_W / 8,
  localparam int unsigned OFF_W  = $clog2(NB)
) (
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [OFF_W-1:0]  off,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rword,
  output logic [NB-1:0]     be,
  output logic [DATA_W-1:0] wdata_sh,
  output logic [DATA_W-1:0] rdata_ext,
  output logic              err
);

  int unsigned       size;
  int unsigned       off_n;
  logic [DATA_W-1:0] shifted;
  logic              sign;

  always_comb begin
    size      = size_bytes(funct3);
    off_n     = 32'(off);
    err       = !legal(funct3, we, DATA_W) || ((off_n & (size - 1)) != 0);
    be        = '0;
    rdata_ext = '0;
    wdata_sh  = wdata << {off, 3'b000};
    shifted   = rword >> {off, 3'b000};
    sign      = 1'b0;
    // Sign bit is the MSB of the accessed field, i.e. bit size*8-1 after shifting down.
    for (int unsigned i = 0; i < DATA_W; i++)
      if (i == size * 8 - 1) sign = shifted[i];
    sign = sign && !is_unsigned(funct3);
    if (!err) begin
      if (we) begin
        for (int unsigned b = 0; b < NB; b++)
          be[b] = (b >= off_n) && (b < off_n + size);
      end else begin
        for (int unsigned i = 0; i < DATA_W; i++)
          rdata_ext[i] = (i < size * 8) ? shifted[i] : sign;
      end
    end
  end

endmodule

// File: rtl/dmem_lsu.sv
// Byte-addressable data memory with a one-entry registered response channel.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(NB);
  localparam int unsigned DEPTH = 1 << (ADDR_W - OFF_W);

  logic [DATA_W-1:0]       mem_q [DEPTH];
  logic [ADDR_W-OFF_W-1:0] idx;
  logic [OFF_W-1:0]        off;
  logic [NB-1:0]           be;
  logic [DATA_W-1:0]       wdata_sh;
  logic [DATA_W-1:0]       rdata_ext;
  logic                    err;
  logic                    accept;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  assign idx       = req_addr[ADDR_W-1:OFF_W];
  assign off       = req_addr[OFF_W-1:0];
  assign req_ready = (state_q == EMPTY) || rsp_ready;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_q == FULL);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  dmem_lane_align #(.DATA_W(DATA_W)) u_align (
    .we       (req_we),
    .funct3   (req_funct3),
    .off      (off),
    .wdata    (req_wdata),
    .rword    (mem_q[idx]),
    .be       (be),
    .wdata_sh (wdata_sh),
    .rdata_ext(rdata_ext),
    .err      (err)
  );

  // Contents survive reset; only enabled lanes are written.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int unsigned b = 0; b < NB; b++)
        if (be[b]) mem_q[idx][b*8 +: 8] <= wdata_sh[b*8 +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = FULL;
          rdata_d = rdata_ext;
          err_d   = err;
        end
      end
      FULL: begin
        if (accept) begin
          rdata_d = rdata_ext;
          err_d   = err;
        end else if (rsp_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Randomised bench: 32- and 64-bit instances in lockstep against a byte-array model.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [8:0]  req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        rsp_ready = 1'b1;

  logic        req_ready32, rsp_valid32, rsp_err32;
  logic [31:0] rsp_rdata32;
  logic        req_ready64, rsp_valid64, rsp_err64;
  logic [63:0] rsp_rdata64;

  always #5 clk = ~clk;

  dmem_lsu #(.DATA_W(32), .ADDR_W(9)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready32),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata[31:0]), .rsp_valid(rsp_valid32), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata32), .rsp_err(rsp_err32)
  );

  dmem_lsu #(.DATA_W(64), .ADDR_W(9)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready64),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid64), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata64), .rsp_err(rsp_err64)
  );

  typedef struct {
    logic [63:0] d;
    logic        e;
  } exp_t;

  logic [7:0]  m32 [512];
  logic [7:0]  m64 [512];
  exp_t        q32 [$];
  exp_t        q64 [$];
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  bit          rand_rr = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Byte-level reference: legality, alignment, little-endian gather, extension.
  function automatic exp_t model(input bit is64, input logic we, input logic [2:0] f,
                                 input logic [8:0] a, input logic [63:0] wd);
    exp_t        r;
    int unsigned size, ai, fi;
    logic        ok;
    size = 1 << f[1:0];
    ai   = a;
    fi   = f;
    if (we) ok = (fi <= 2) || (fi == 3 && is64);
    else    ok = (fi inside {0, 1, 2, 4, 5}) || (is64 && fi inside {3, 6});
    r.e = !ok || (ai % size != 0);
    r.d = '0;
    if (!r.e) begin
      for (int unsigned k = 0; k < size; k++) begin
        if (we) begin
          if (is64) m64[ai+k] = wd[8*k +: 8];
          else      m32[ai+k] = wd[8*k +: 8];
        end else begin
          r.d[8*k +: 8] = is64 ? m64[ai+k] : m32[ai+k];
        end
      end
      if (!we && !f[2] && r.d[8*size-1])
        for (int unsigned j = 8 * size; j < 64; j++) r.d[j] = 1'b1;
      if (!is64) r.d[63:32] = '0;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      check("rsp_valid32", {63'b0, rsp_valid32}, {63'b0, q32.size() != 0});
      check("rsp_valid64", {63'b0, rsp_valid64}, {63'b0, q64.size() != 0});
      check("req_ready32", {63'b0, req_ready32}, {63'b0, q32.size() == 0 || rsp_ready});
      check("req_ready64", {63'b0, req_ready64}, {63'b0, q64.size() == 0 || rsp_ready});
      if (q32.size() != 0) begin
        check("rdata32", {32'b0, rsp_rdata32}, q32[0].d);
        check("err32", {63'b0, rsp_err32}, {63'b0, q32[0].e});
        if (rsp_ready) void'(q32.pop_front());
      end
      if (q64.size() != 0) begin
        check("rdata64", rsp_rdata64, q64[0].d);
        check("err64", {63'b0, rsp_err64}, {63'b0, q64[0].e});
        if (rsp_ready) void'(q64.pop_front());
      end
      if (req_valid && req_ready32)
        q32.push_back(model(1'b0, req_we, req_funct3, req_addr, req_wdata));
      if (req_valid && req_ready64)
        q64.push_back(model(1'b1, req_we, req_funct3, req_addr, req_wdata));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rr) rsp_ready = ($urandom % 4) != 0;
  endtask

  task automatic issue(input logic we, input logic [2:0] f, input logic [8:0] a,
                       input logic [63:0] wd);
    int unsigned n;
    logic        acc;
    n          = 0;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f;
    req_addr   = a;
    req_wdata  = wd;
    do begin
      @(negedge clk);
      acc = req_ready32;
      step();
      n++;
    end while (!acc && n < 100);
    if (!acc) check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle();
    req_valid = 1'b0;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  f;
    logic [8:0]  a;
    logic [63:0] wd;
    int unsigned sz;

    #1;
    check("rst_valid32", {63'b0, rsp_valid32}, 64'd0);
    check("rst_rdata32", {32'b0, rsp_rdata32}, 64'd0);
    check("rst_err32", {63'b0, rsp_err32}, 64'd0);
    check("rst_ready32", {63'b0, req_ready32}, 64'd1);
    check("rst_valid64", {63'b0, rsp_valid64}, 64'd0);
    check("rst_rdata64", rsp_rdata64, 64'd0);
    check("rst_ready64", {63'b0, req_ready64}, 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int unsigned i = 0; i < 512; i += 4)
      issue(1'b1, 3'b010, 9'(i), {$urandom, $urandom});
    idle();

    issue(1'b1, 3'b010, 9'h010, 64'hDEADBEEF);
    issue(1'b0, 3'b010, 9'h010, 64'h0);
    issue(1'b1, 3'b000, 9'h013, 64'h80);
    issue(1'b0, 3'b000, 9'h013, 64'h0);
    issue(1'b0, 3'b100, 9'h013, 64'h0);
    issue(1'b0, 3'b101, 9'h012, 64'h0);
    issue(1'b1, 3'b010, 9'h021, 64'h12345678);
    issue(1'b0, 3'b010, 9'h020, 64'h0);
    issue(1'b0, 3'b001, 9'h001, 64'h0);
    issue(1'b1, 3'b011, 9'h008, 64'h8000000000000001);
    issue(1'b0, 3'b011, 9'h008, 64'h0);
    issue(1'b0, 3'b010, 9'h00C, 64'h0);
    issue(1'b0, 3'b110, 9'h00C, 64'h0);
    issue(1'b0, 3'b111, 9'h000, 64'h0);
    issue(1'b1, 3'b100, 9'h004, 64'h55);
    idle();

    // Backpressure: response held three cycles with a request waiting.
    issue(1'b0, 3'b010, 9'h010, 64'h0);
    rsp_ready  = 1'b0;
    req_addr   = 9'h014;
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_ready32", {63'b0, req_ready32}, 64'd0);
      check("bp_ready64", {63'b0, req_ready64}, 64'd0);
      step();
    end
    rsp_ready = 1'b1;
    issue(1'b0, 3'b010, 9'h014, 64'h0);
    issue(1'b0, 3'b011, 9'h010, 64'h0);
    idle();

    rand_rr = 1'b1;
    for (int unsigned i = 0; i < 400; i++) begin
      if ($urandom % 5 == 0) idle();
      else begin
        f  = 3'($urandom);
        a  = 9'($urandom);
        sz = 1 << f[1:0];
        if ($urandom % 10 < 7) a = a & ~9'(sz - 1);
        wd = {$urandom, $urandom};
        issue(1'($urandom), f, a, wd);
      end
    end
    rand_rr   = 1'b0;
    rsp_ready = 1'b1;
    idle();
    idle();

    // Reset while a response is pending: discarded at once, memory kept.
    rsp_ready = 1'b0;
    issue(1'b0, 3'b010, 9'h010, 64'h0);
    req_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid32", {63'b0, rsp_valid32}, 64'd0);
    check("midrst_ready32", {63'b0, req_ready32}, 64'd1);
    check("midrst_valid64", {63'b0, rsp_valid64}, 64'd0);
    check("midrst_ready64", {63'b0, req_ready64}, 64'd1);
    q32.delete();
    q64.delete();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    issue(1'b0, 3'b010, 9'h008, 64'h0);
    issue(1'b0, 3'b011, 9'h008, 64'h0);
    issue(1'b0, 3'b010, 9'h010, 64'h0);
    issue(1'b0, 3'b101, 9'h012, 64'h0);
    idle();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Parametrised, byte-addressable data memory with an integrated load/store unit for the pipeline's MEM stage. Accepts one load or store per cycle over a valid/ready request channel and returns exactly one response per request over a valid/ready response channel. Handles full RV32/RV64 load/store width decoding, byte-lane alignment by address offset, sign/zero extension, and misalignment detection. Supersedes the fixed 32-bit, 9-bit-address data memory.

## Interface
- `DATA_W`, 32: word width; legal values are 32 or 64.
- `ADDR_W`, 9: byte-address width; depth = 2^(ADDR_W − log2(DATA_W/8)) words.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted on a cycle where `req_valid && req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: instruction bits [14:12].
- `req_addr` in ADDR_W: byte address (ALU result LSBs).
- `req_wdata` in DATA_W: store data, right-aligned.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed on a cycle where `rsp_valid && rsp_ready`.
- `rsp_rdata` out DATA_W: extended load data; 0 for stores and errors.
- `rsp_err` out 1: misaligned or illegal-funct3 access.

## Operation
- Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. With DATA_W=64, also 011 LD and 110 LWU.
- Stores: 000 SB, 001 SH, 010 SW. With DATA_W=64, also 011 SD.
- Any other funct3 is illegal. An illegal or misaligned access sets `rsp_err=1`.
- Misaligned means the address is not a multiple of the access size in bytes.
- Error accesses never write memory.
- Store:
  - Byte enables = size mask shifted left by the address offset within the word.
  - Write data = `req_wdata` shifted left by offset×8.
  - Only enabled bytes are written, at the accept edge.
- Load:
  - Reads the full word at the accept edge.
  - Extracts bytes starting at the offset.
  - Sign-extends (LB/LH/LW) or zero-extends (LBU/LHU/LWU/LD) to DATA_W.
- Memory contents are not reset and are not cleared by `rst_n`.
- FSM states:
  - EMPTY (`rsp_valid=0`) → FULL on accept.
  - FULL (`rsp_valid=1`) → EMPTY when the response is consumed with no new accept.
  - FULL → FULL when consume and accept happen in the same cycle.
- `req_ready = !rsp_valid || rsp_ready`. This is combinational, with no combinational path from `req_valid` to `req_ready`.
- While FULL and `rsp_ready=0`, `rsp_*` outputs are held stable and no request is accepted.
- Reset values: `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`, state EMPTY. `req_ready` is therefore 1 during and after reset.
- If reset is asserted mid-operation, the pending response is discarded. A store accepted at an earlier edge remains written.

## Timing
- Latency: 1 cycle. A request accepted at edge N has its response valid from edge N onward (visible in cycle N+1).
- Throughput: 1 request/cycle while `rsp_ready=1`.
- Store followed by a load to the same word on the next accepted cycle returns the new data. Writes land at the earlier edge, so no forwarding is needed.
- Partial-word store followed by a load sees the merged word; untouched bytes are unchanged.
- No request and response combinational loop: `rsp_*` are registers only.

## Structure
- `dmem_pkg` holds:
  - `funct3_e` enum (LB/LH/LW/LD/LBU/LHU/LWU; SB/SH/SW/SD share codes).
  - `function automatic` helpers: `size_bytes(funct3)`, `is_unsigned(funct3)`, `legal(funct3, we, DATA_W)`.
- Sub-module `dmem_lane_align` (combinational) produces:
  - the store byte-enable mask and shifted write data;
  - the load extract-and-extend result;
  - the misalign/illegal flag.
- Top level holds the memory array (byte-enable write, synchronous read), the response register, and the FSM.

## Test plan
- Reset with `rsp_ready=1`; SW 0xDEADBEEF @0x10; LW @0x10 → response 1 cycle after accept: `rsp_rdata=0xDEADBEEF`, `err=0`.
- Byte and half lanes: SB 0x80 @0x13, then LB @0x13 → 0xFFFFFF80; LBU @0x13 → 0x00000080; LHU @0x12 → 0x000080AD.
- Misalignment:
  - SW 0x12345678 @0x21 → `err=1`; a following LW @0x20 → unchanged prior value.
  - LH @0x01 → `err=1`, `rdata=0`.
- Backpressure: hold `rsp_ready=0` for 3 cycles with `req_valid=1` → `req_ready=0`, `rsp_*` stable, no extra accept; release → back-to-back responses in order.
- DATA_W=64:
  - SD 0x8000000000000001 @0x8; LD @0x8 → same value.
  - LW @0xC → 0xFFFFFFFF80000000; LWU @0xC → 0x0000000080000000.
  - funct3=011 at DATA_W=32 → `err=1`.
- Assert `rst_n` low while FULL → `rsp_valid=0` immediately (asynchronous), `req_ready=1`; data previously stored is still readable after reset.
